// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
//
// Receive buffer between UART_RX and the 68000 bus decode. Bytes from the
// receiver are queued in arrival order. The bus-side data register presents
// the head byte, and rxf_n reports whether a byte is waiting. This lets bursts
// arriving at 115200 baud survive while the CPU is busy.
//
// Optional feature macro: RX_FIFO_OVERRUN_EN
//   When defined, the ports clr_overrun/overrun are added. overrun is a sticky
//   drop flag. When undefined, dropped bytes are silent.
//
// Parameters
//   DEPTH_LOG2   log2 of FIFO depth (default 4 -> 16 entries), 1..8
//
// Ports
//   clk12        in   12 MHz system clock, all logic on posedge
//   rst          in   synchronous active-high reset
//   rx_dv        in   1-cycle pulse: rx_byte valid
//   rx_byte      in   received byte
//   rd_strobe    in   high while a CPU read of the data register is in progress
//   clr_overrun  in   (RX_FIFO_OVERRUN_EN) clear the sticky overrun flag
//   overrun      out  (RX_FIFO_OVERRUN_EN) sticky flag, set on every dropped byte
//   rd_data      out  head byte, registered
//   rxf_n        out  0 = at least one byte queued
//   level        out  number of queued bytes, 0..2**DEPTH_LOG2
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                clk12,
  input  logic                rst,
  input  logic                rx_dv,
  input  logic [7:0]          rx_byte,
  input  logic                rd_strobe,
`ifdef RX_FIFO_OVERRUN_EN
  input  logic                clr_overrun,
  output logic                overrun,
`endif
  output logic [7:0]          rd_data,
  output logic                rxf_n,
  output logic [DEPTH_LOG2:0] level
);

  localparam int                  DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = DEPTH[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0] LVL_ZERO   = (DEPTH_LOG2+1)'(32'd0);
  localparam logic [DEPTH_LOG2:0] LVL_ONE    = (DEPTH_LOG2+1)'(32'd1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = DEPTH_LOG2'(32'd0);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(32'd1);

  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic [7:0]            r_rd_data;
  logic                  r_rxf_n;
  logic                  r_strobe_d;

  logic                  w_full;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_head_from_push;
  logic [DEPTH_LOG2:0]   w_level_nxt;
  logic [DEPTH_LOG2-1:0] w_rd_ptr_nxt;
  logic [7:0]            w_rd_data_nxt;

  // Push/pop decisions, next level and next presented head byte.
  always_comb begin
    w_full           = (r_level == FULL_LEVEL);
    // Pop only on the strobe's falling edge, so one bus access pops once and
    // rd_data holds still while the strobe is high.
    w_pop            = r_strobe_d & ~rd_strobe & (r_level != LVL_ZERO);
    // A simultaneous pop frees a slot, so a push at full is still accepted.
    w_push           = rx_dv & (~w_full | w_pop);
    w_level_nxt      = r_level;
    w_rd_ptr_nxt     = r_rd_ptr;
    w_head_from_push = 1'b0;
    w_rd_data_nxt    = r_rd_data;

    if (w_push && !w_pop) begin
      w_level_nxt = r_level + LVL_ONE;
    end else if (w_pop && !w_push) begin
      w_level_nxt = r_level - LVL_ONE;
    end else begin
      w_level_nxt = r_level;
    end

    if (w_pop) begin
      w_rd_ptr_nxt = r_rd_ptr + PTR_ONE;
    end else begin
      w_rd_ptr_nxt = r_rd_ptr;
    end

    // The byte being pushed becomes the head when nothing else remains queued;
    // it is not in memory yet, so it is forwarded straight from the input.
    w_head_from_push = w_push &&
                       ((r_level == LVL_ZERO) || (w_pop && (r_level == LVL_ONE)));

    if (w_level_nxt == LVL_ZERO) begin
      w_rd_data_nxt = r_rd_data;
    end else if (w_head_from_push) begin
      w_rd_data_nxt = rx_byte;
    end else begin
      w_rd_data_nxt = r_mem[w_rd_ptr_nxt];
    end
  end

  // Storage array. It is not cleared by reset, and a push is blocked during reset.
  always_ff @(posedge clk12) begin
    if (w_push && !rst) begin
      r_mem[r_wr_ptr] <= rx_byte;
    end
  end

  // Pointers, level, strobe history and registered bus-side outputs.
  always_ff @(posedge clk12) begin
    if (rst) begin
      r_wr_ptr   <= PTR_ZERO;
      r_rd_ptr   <= PTR_ZERO;
      r_level    <= LVL_ZERO;
      r_rd_data  <= 8'h00;
      r_rxf_n    <= 1'b1;
      r_strobe_d <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_level    <= w_level_nxt;
      r_rd_data  <= w_rd_data_nxt;
      r_rxf_n    <= (w_level_nxt == LVL_ZERO);
      r_strobe_d <= rd_strobe;
    end
  end

`ifdef RX_FIFO_OVERRUN_EN
  logic r_overrun;
  logic w_drop;

  // A byte is dropped when it arrives but cannot be accepted.
  always_comb begin
    w_drop = rx_dv & ~w_push;
  end

  // Sticky overrun flag. A drop in the same cycle as a clear takes priority.
  always_ff @(posedge clk12) begin
    if (rst) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (clr_overrun) begin
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= r_overrun;
    end
  end

  assign overrun = r_overrun;
`endif

  assign rd_data = r_rd_data;
  assign rxf_n   = r_rxf_n;
  assign level   = r_level;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo
//
// Self-checking bench for uart_rx_fifo. It runs a queue-based reference model
// that is updated once per clock edge. The bench first applies directed
// scenarios, then randomized traffic with occasional resets.
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo;

  localparam int DL2   = 4;
  localparam int DEPTH = 1 << DL2;

  logic         clk12 = 1'b0;
  logic         rst;
  logic         rx_dv;
  logic [7:0]   rx_byte;
  logic         rd_strobe;
  logic [7:0]   rd_data;
  logic         rxf_n;
  logic [DL2:0] level;
`ifdef RX_FIFO_OVERRUN_EN
  logic         clr_overrun;
  logic         overrun;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [7:0]   q[$];
  logic [7:0]   m_data;
  logic         m_strobe_prev;
  logic         m_ovr;

  uart_rx_fifo #(.DEPTH_LOG2(DL2)) dut (
    .clk12      (clk12),
    .rst        (rst),
    .rx_dv      (rx_dv),
    .rx_byte    (rx_byte),
    .rd_strobe  (rd_strobe),
`ifdef RX_FIFO_OVERRUN_EN
    .clr_overrun(clr_overrun),
    .overrun    (overrun),
`endif
    .rd_data    (rd_data),
    .rxf_n      (rxf_n),
    .level      (level)
  );

  always #5 clk12 = ~clk12;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model over the edge, then compare.
  task automatic step(input logic dv, input logic [7:0] b, input logic s,
                      input logic r, input logic clr);
    logic pop_ev;
    logic accept;
    rx_dv     = dv;
    rx_byte   = b;
    rd_strobe = s;
    rst       = r;
`ifdef RX_FIFO_OVERRUN_EN
    clr_overrun = clr;
`endif
    @(posedge clk12);
    if (r) begin
      q.delete();
      m_data        = 8'h00;
      m_strobe_prev = 1'b0;
      m_ovr         = 1'b0;
    end else begin
      pop_ev = m_strobe_prev && !s && (q.size() > 0);
      accept = dv && ((q.size() < DEPTH) || pop_ev);
      if (pop_ev) void'(q.pop_front());
      if (accept) q.push_back(b);
      if (q.size() > 0) m_data = q[0];
      if (dv && !accept) m_ovr = 1'b1;
      else if (clr) m_ovr = 1'b0;
      m_strobe_prev = s;
    end
    #1;
    chk("rd_data", 32'(rd_data), 32'(m_data));
    chk("rxf_n", 32'(rxf_n), (q.size() == 0) ? 32'd1 : 32'd0);
    chk("level", 32'(level), 32'(q.size()));
`ifdef RX_FIFO_OVERRUN_EN
    chk("overrun", 32'(overrun), 32'(m_ovr));
`endif
  endtask

  task automatic push(input logic [7:0] b);
    step(1'b1, b, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic read_one();
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int hold;
    logic s;
    m_data = 8'h00; m_strobe_prev = 1'b0; m_ovr = 1'b0;
    rst = 1'b1; rx_dv = 1'b0; rx_byte = 8'h00; rd_strobe = 1'b0;
`ifdef RX_FIFO_OVERRUN_EN
    clr_overrun = 1'b0;
`endif

    // Reset state
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("reset_rd_data", 32'(rd_data), 32'h00);
    chk("reset_rxf_n", 32'(rxf_n), 32'd1);
    chk("reset_level", 32'(level), 32'd0);

    // 1: single push is visible the next cycle
    push(8'h41);
    chk("t1_rd_data", 32'(rd_data), 32'h41);
    chk("t1_rxf_n", 32'(rxf_n), 32'd0);
    chk("t1_level", 32'(level), 32'd1);
    read_one();
    chk("t1_empty", 32'(rxf_n), 32'd1);

    // 2: long strobe pops exactly once, after the fall
    push(8'h01); push(8'h02); push(8'h03);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("t2_hold", 32'(rd_data), 32'h01);
    end
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("t2_next", 32'(rd_data), 32'h02);
    chk("t2_level", 32'(level), 32'd2);
    read_one(); read_one();

    // 3: fill, then overflow drops a byte; read back in order
    for (int i = 0; i < DEPTH; i++) push(8'(8'h10 + i));
    push(8'hAA);
    chk("t3_full", 32'(level), 32'd16);
`ifdef RX_FIFO_OVERRUN_EN
    chk("t3_overrun", 32'(overrun), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("t3_clr", 32'(overrun), 32'd0);
`endif
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("t3_read", 32'(rd_data), 32'(8'h10 + i));
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    end
    chk("t3_empty", 32'(rxf_n), 32'd1);

    // 4: pop and push together at full
    for (int i = 0; i < DEPTH; i++) push(8'(8'h20 + i));
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    chk("t4_level", 32'(level), 32'd16);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("t4_read", 32'(rd_data), (i == DEPTH-1) ? 32'h55 : 32'(8'h21 + i));
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    end

    // 5: empty read is ignored
    read_one();
    chk("t5_level", 32'(level), 32'd0);
    chk("t5_rxf_n", 32'(rxf_n), 32'd1);
    chk("t5_rd_data", 32'(rd_data), 32'h55);
    push(8'h7E);
    chk("t5_push", 32'(rd_data), 32'h7E);
    read_one();

    // 6: reset mid-operation with the strobe high
    push(8'h31); push(8'h32); push(8'h33);
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    chk("t6_level", 32'(level), 32'd0);
    chk("t6_rxf_n", 32'(rxf_n), 32'd1);
    chk("t6_rd_data", 32'(rd_data), 32'h00);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("t6_fall", 32'(level), 32'd0);
    // A push before the fall is popped by it
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    step(1'b1, 8'h66, 1'b1, 1'b0, 1'b0);
    chk("t6_push", 32'(rd_data), 32'h66);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("t6_pop", 32'(level), 32'd0);

    // Randomized traffic in phases biased toward filling and draining
    s = 1'b0;
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      logic dv;
      int dv_pct;
      dv_pct = ((c / 300) % 2 == 0) ? 70 : 25;
      dv = ($urandom_range(99) < dv_pct);
      if (hold == 0) begin
        s = ~s;
        hold = $urandom_range(5, 0);
      end else begin
        hold--;
      end
      step(dv, 8'($urandom), s, ($urandom_range(499) == 0),
           ($urandom_range(19) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
